mem_scheduler: RTL



---
 rtl/mem_sched_pkg.sv | 22 ++
 rtl/mem_sched_pick.sv | 31 +++
 rtl/mem_scheduler.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/mem_sched_pkg.sv
// Shared types and sizes for the memory scheduler.
// The PREFETCH_EN macro is consumed by mem_scheduler.
package mem_sched_pkg;

  localparam int LINE_W = 256;
  localparam int ADDR_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    GRANT_P = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2,
    OWN_P    = 2'd3
  } owner_t;

endpackage

// File: rtl/mem_sched_pick.sv
// Combinational owner selection: starvation override for icache, else D > I > P.
module mem_sched_pick
  import mem_sched_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic             i_req,
  input  logic             d_req,
  input  logic             p_req,
  input  logic [CNT_W-1:0] starve_cnt,
  output logic [1:0]       next_owner
);

  // priority pick with icache forced once it has waited STARVE_LIMIT dcache grants
  always_comb begin
    next_owner = OWN_NONE;
    if (i_req && (starve_cnt == CNT_W'(STARVE_LIMIT))) begin
      next_owner = OWN_I;
    end else if (d_req) begin
      next_owner = OWN_D;
    end else if (i_req) begin
      next_owner = OWN_I;
    end else if (p_req) begin
      next_owner = OWN_P;
    end else begin
      next_owner = OWN_NONE;
    end
  end

endmodule

// File: rtl/mem_scheduler.sv
// Arbitrates icache, dcache and (with PREFETCH_EN defined) prefetcher line
// requests onto a single cacheline adaptor, one transaction at a time.
module mem_scheduler
  import mem_sched_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_read,
  input  logic [ADDR_W-1:0]   i_address,
  output logic [LINE_W-1:0]   i_rdata,
  output logic                i_resp,
  input  logic                d_read,
  input  logic                d_write,
  input  logic [ADDR_W-1:0]   d_address,
  input  logic [LINE_W-1:0]   d_wdata,
  output logic [LINE_W-1:0]   d_rdata,
  output logic                d_resp,
  input  logic                p_read,
  input  logic [ADDR_W-1:0]   p_address,
  output logic [LINE_W-1:0]   p_rdata,
  output logic                p_resp,
  output logic                a_read,
  output logic                a_write,
  output logic [ADDR_W-1:0]   a_address,
  output logic [LINE_W-1:0]   a_wdata,
  input  logic [LINE_W-1:0]   a_rdata,
  input  logic                a_resp,
  output logic [1:0]          grant_id
);

  state_t           state_r;
  state_t           state_nxt_s;
  logic [CNT_W-1:0] starve_cnt_r;
  logic [1:0]       pick_s;
  logic             d_req_s;
  logic             p_req_s;

  assign d_req_s = d_read | d_write;

`ifdef PREFETCH_EN
  assign p_req_s = p_read;
`else
  logic unused_s;
  assign p_req_s  = 1'b0;
  assign unused_s = ^{p_read, p_address};
`endif

  mem_sched_pick #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CNT_W        (CNT_W)
  ) u_pick (
    .i_req      (i_read),
    .d_req      (d_req_s),
    .p_req      (p_req_s),
    .starve_cnt (starve_cnt_r),
    .next_owner (pick_s)
  );

  // next-state: grants only start from IDLE, and only a_resp ends them
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        case (pick_s)
          OWN_D:   state_nxt_s = GRANT_D;
          OWN_I:   state_nxt_s = GRANT_I;
`ifdef PREFETCH_EN
          OWN_P:   state_nxt_s = GRANT_P;
`endif
          default: state_nxt_s = IDLE;
        endcase
      end
`ifdef PREFETCH_EN
      GRANT_I, GRANT_D, GRANT_P: begin
`else
      GRANT_I, GRANT_D: begin
`endif
        if (a_resp) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // state register and icache starvation counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      starve_cnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if ((state_r == IDLE) && (state_nxt_s == GRANT_I)) begin
        starve_cnt_r <= {CNT_W{1'b0}};
      end else if ((state_r == IDLE) && (state_nxt_s == GRANT_D) && i_read &&
                   (starve_cnt_r != CNT_W'(STARVE_LIMIT))) begin
        starve_cnt_r <= starve_cnt_r + CNT_W'(1);
      end else begin
        starve_cnt_r <= starve_cnt_r;
      end
    end
  end

  // adaptor request mux and response steering; a read+write from dcache is a write
  always_comb begin
    a_read    = 1'b0;
    a_write   = 1'b0;
    a_address = {ADDR_W{1'b0}};
    a_wdata   = {LINE_W{1'b0}};
    i_resp    = 1'b0;
    i_rdata   = {LINE_W{1'b0}};
    d_resp    = 1'b0;
    d_rdata   = {LINE_W{1'b0}};
    p_resp    = 1'b0;
    p_rdata   = {LINE_W{1'b0}};
    case (state_r)
      GRANT_I: begin
        a_read    = i_read;
        a_address = i_address;
        if (a_resp && !rst) begin
          i_resp  = 1'b1;
          i_rdata = a_rdata;
        end else begin
          i_resp  = 1'b0;
        end
      end
      GRANT_D: begin
        a_read    = d_read & ~d_write;
        a_write   = d_write;
        a_address = d_address;
        a_wdata   = d_wdata;
        if (a_resp && !rst) begin
          d_resp  = 1'b1;
          d_rdata = a_rdata;
        end else begin
          d_resp  = 1'b0;
        end
      end
`ifdef PREFETCH_EN
      GRANT_P: begin
        a_read    = p_read;
        a_address = p_address;
        if (a_resp && !rst) begin
          p_resp  = 1'b1;
          p_rdata = a_rdata;
        end else begin
          p_resp  = 1'b0;
        end
      end
`endif
      default: begin
        a_read  = 1'b0;
        a_write = 1'b0;
      end
    endcase
  end

  assign grant_id = state_r;

endmodule
